// File: rtl/cia_tod_pkg.sv
// Shared types and digit arithmetic for the CIA time-of-day clock.
// Field layout follows the 6526 TOD register map; unused register bits are not stored.
package cia_tod_pkg;

  typedef struct packed {
    logic       pm;
    logic [4:0] hr;
    logic [6:0] min;
    logic [6:0] sec;
    logic [3:0] tenths;
  } tod_t;

  typedef enum logic [1:0] {
    TOD_TENTHS = 2'd0,
    TOD_SEC    = 2'd1,
    TOD_MIN    = 2'd2,
    TOD_HR     = 2'd3
  } tod_addr_t;

  localparam tod_t TOD_RESET   = '{pm: 1'b0, hr: 5'h01, min: 7'h00, sec: 7'h00, tenths: 4'h0};
  localparam tod_t ALARM_RESET = '{pm: 1'b0, hr: 5'h00, min: 7'h00, sec: 7'h00, tenths: 4'h0};

  // Returns {carry, next}: a digit at its max wraps and carries, anything else is +1 mod 16.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] max);
    if (d == max) return {1'b1, 4'h0};
    return {1'b0, d + 4'h1};
  endfunction

  // Seconds/minutes: units digit 0-9 carrying into a 3-bit tens digit 0-5. Returns {carry, next}.
  function automatic logic [7:0] sexa_step(input logic [6:0] v);
    logic [2:0] tens;
    logic       carry;
    tens  = v[6:4];
    carry = 1'b0;
    if (v[3:0] == 4'd9) begin
      if (v[6:4] == 3'd5) begin
        tens  = 3'd0;
        carry = 1'b1;
      end else begin
        tens = v[6:4] + 3'd1;
      end
    end
    return {carry, tens, (v[3:0] == 4'd9) ? 4'h0 : v[3:0] + 4'h1};
  endfunction

  // Hours: 12 -> 01 keeps pm, 11 -> 12 toggles pm, otherwise plain BCD step. Returns {pm, hr}.
  function automatic logic [5:0] hour_step(input logic pm, input logic [4:0] hr);
    if (hr == 5'h12) return {pm, 5'h01};
    if (hr == 5'h11) return {~pm, 5'h12};
    if (hr[3:0] == 4'd9) return {pm, ~hr[4], 4'h0};
    return {pm, hr[4], hr[3:0] + 4'h1};
  endfunction

endpackage

// File: rtl/cia_tod_prescaler.sv
// TOD pin edge detector and 5/6 divider producing one tick per tenth of a second.
// The count is held at zero whenever the clock is halted or explicitly cleared.
module cia_tod_prescaler (
  input  logic clk,
  input  logic rst,
  input  logic tod_in,
  input  logic run,
  input  logic clear,
  input  logic sel_50hz,
  output logic tick
);

  logic       tod_prev;
  logic [2:0] count;
  logic       rise;
  logic       at_limit;

  assign rise     = tod_in & ~tod_prev & run;
  assign at_limit = (count == (sel_50hz ? 3'd4 : 3'd5));
  assign tick     = rise & at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tod_prev <= 1'b0;
      count    <= 3'd0;
    end else begin
      tod_prev <= tod_in;
      if (clear || !run) begin
        count <= 3'd0;
      end else if (rise) begin
        count <= at_limit ? 3'd0 : count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/cia_tod_clock.sv
// CIA time-of-day clock: BCD cascade, register writes, read latch and alarm pulse.
// Build option CIA_TOD_PM_FLIP_EN: hours write of 12 inverts the written pm bit (6526 quirk).
module cia_tod_clock
  import cia_tod_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tod_in,
  input  logic       sel_50hz,
  input  logic       alarm_sel,
  input  logic       we,
  input  logic       re,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       alarm_irq
);

  tod_t      tod, tod_next;
  tod_t      alarm, alarm_next;
  tod_t      latch, view;
  logic      running;
  logic      latched;
  logic      changed;
  logic      tick;
  logic      wr_tod;
  logic      wr_alarm;
  tod_addr_t reg_sel;
  logic [4:0] t_step;
  logic [7:0] s_step;
  logic [7:0] m_step;
  logic [5:0] h_step;

  assign reg_sel  = tod_addr_t'(addr);
  assign wr_tod   = we & ~alarm_sel;
  assign wr_alarm = we & alarm_sel;

  cia_tod_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .tod_in   (tod_in),
    .run      (running),
    .clear    (wr_tod && (reg_sel == TOD_TENTHS)),
    .sel_50hz (sel_50hz),
    .tick     (tick)
  );

  // Cascade from current values, then let a same-cycle write override its own field.
  always_comb begin
    tod_next = tod;
    t_step   = bcd_step(tod.tenths, 4'd9);
    s_step   = sexa_step(tod.sec);
    m_step   = sexa_step(tod.min);
    h_step   = hour_step(tod.pm, tod.hr);
    if (tick) begin
      tod_next.tenths = t_step[3:0];
      if (t_step[4]) begin
        tod_next.sec = s_step[6:0];
        if (s_step[7]) begin
          tod_next.min = m_step[6:0];
          if (m_step[7]) begin
            tod_next.pm = h_step[5];
            tod_next.hr = h_step[4:0];
          end
        end
      end
    end
    if (wr_tod) begin
      case (reg_sel)
        TOD_TENTHS: tod_next.tenths = wdata[3:0];
        TOD_SEC:    tod_next.sec    = wdata[6:0];
        TOD_MIN:    tod_next.min    = wdata[6:0];
        TOD_HR: begin
          tod_next.hr = wdata[4:0];
          tod_next.pm = wdata[7];
`ifdef CIA_TOD_PM_FLIP_EN
          if (wdata[4:0] == 5'h12) tod_next.pm = ~wdata[7];
`endif
        end
      endcase
    end
  end

  always_comb begin
    alarm_next = alarm;
    if (wr_alarm) begin
      case (reg_sel)
        TOD_TENTHS: alarm_next.tenths = wdata[3:0];
        TOD_SEC:    alarm_next.sec    = wdata[6:0];
        TOD_MIN:    alarm_next.min    = wdata[6:0];
        TOD_HR: begin
          alarm_next.hr = wdata[4:0];
          alarm_next.pm = wdata[7];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tod       <= TOD_RESET;
      alarm     <= ALARM_RESET;
      latch     <= TOD_RESET;
      running   <= 1'b0;
      latched   <= 1'b0;
      changed   <= 1'b0;
      alarm_irq <= 1'b0;
    end else begin
      tod   <= tod_next;
      alarm <= alarm_next;
      if (wr_tod && reg_sel == TOD_HR) begin
        running <= 1'b0;
      end else if (wr_tod && reg_sel == TOD_TENTHS) begin
        running <= 1'b1;
      end
      if (re && reg_sel == TOD_HR && !latched) begin
        latch   <= tod;
        latched <= 1'b1;
      end else if (re && reg_sel == TOD_TENTHS) begin
        latched <= 1'b0;
      end
      // Pulse only on the cycle after a change lands on a match, never while static.
      changed   <= (tod_next != tod) || (alarm_next != alarm);
      alarm_irq <= changed && (tod == alarm);
    end
  end

  assign view = latched ? latch : tod;

  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      TOD_TENTHS: rdata = {4'h0, view.tenths};
      TOD_SEC:    rdata = {1'b0, view.sec};
      TOD_MIN:    rdata = {1'b0, view.min};
      TOD_HR:     rdata = {view.pm, 2'b00, view.hr};
    endcase
  end

endmodule

// File: tb/tb_cia_tod_clock.sv
// Directed bench for cia_tod_clock: cascade, halt/resume, read latch, alarm pulse, reset.
module tb_cia_tod_clock;

  logic       clk;
  logic       rst;
  logic       tod_in;
  logic       sel_50hz;
  logic       alarm_sel;
  logic       we;
  logic       re;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       alarm_irq;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_cnt  = 0;
  int irq_base;
  logic [7:0] rd;

  localparam logic [1:0] A_TEN = 2'd0;
  localparam logic [1:0] A_SEC = 2'd1;
  localparam logic [1:0] A_MIN = 2'd2;
  localparam logic [1:0] A_HR  = 2'd3;

`ifdef CIA_TOD_PM_FLIP_EN
  localparam logic [7:0] HR12_PM_W  = 8'h12;
  localparam logic [7:0] HR12_AM_RD = 8'h92;
`else
  localparam logic [7:0] HR12_PM_W  = 8'h92;
  localparam logic [7:0] HR12_AM_RD = 8'h12;
`endif

  cia_tod_clock dut (
    .clk       (clk),
    .rst       (rst),
    .tod_in    (tod_in),
    .sel_50hz  (sel_50hz),
    .alarm_sel (alarm_sel),
    .we        (we),
    .re        (re),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .alarm_irq (alarm_irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && alarm_irq) irq_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d, input logic asel);
    addr = a; wdata = d; alarm_sel = asel; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; alarm_sel = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    #1;
    d = rdata;
    @(posedge clk);
    #1;
    re = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic tod_edges(input int n);
    for (int i = 0; i < n; i++) begin
      tod_in = 1'b1;
      @(posedge clk);
      #1;
      tod_in = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic [7:0] t);
    write_reg(A_HR, h, 1'b0);
    write_reg(A_MIN, m, 1'b0);
    write_reg(A_SEC, s, 1'b0);
    write_reg(A_TEN, t, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tod_in = 1'b0; sel_50hz = 1'b0; alarm_sel = 1'b0;
    we = 1'b0; re = 1'b0; addr = 2'd0; wdata = 8'h00;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    // reset state, clock halted until tenths is written
    peek(A_TEN, rd); check_eq("rst_tenths", rd, 8'h00);
    peek(A_SEC, rd); check_eq("rst_sec", rd, 8'h00);
    peek(A_MIN, rd); check_eq("rst_min", rd, 8'h00);
    peek(A_HR, rd);  check_eq("rst_hr", rd, 8'h01);
    check_eq("rst_irq", alarm_irq, 1'b0);
    tod_edges(12);
    peek(A_TEN, rd); check_eq("halted_after_rst", rd, 8'h00);

    // 1: 60 Hz divider
    write_reg(A_TEN, 8'h00, 1'b0);
    tod_edges(5);
    peek(A_TEN, rd); check_eq("div6_5edges", rd, 8'h00);
    tod_edges(1);
    peek(A_TEN, rd); check_eq("div6_6edges", rd, 8'h01);

    // 2: 11 -> 12 toggles pm, 12 -> 01 keeps pm
    preset(8'h11, 8'h59, 8'h59, 8'h09);
    tod_edges(6);
    peek(A_TEN, rd); check_eq("am_pm_tenths", rd, 8'h00);
    peek(A_SEC, rd); check_eq("am_pm_sec", rd, 8'h00);
    peek(A_MIN, rd); check_eq("am_pm_min", rd, 8'h00);
    peek(A_HR, rd);  check_eq("am_pm_hr", rd, 8'h92);
    preset(HR12_PM_W, 8'h59, 8'h59, 8'h09);
    tod_edges(6);
    peek(A_HR, rd);  check_eq("hr12_to_01", rd, 8'h81);
    peek(A_MIN, rd); check_eq("hr12_to_01_min", rd, 8'h00);

    // 3: hours write halts, tenths write resumes with a fresh divider
    write_reg(A_HR, 8'h03, 1'b0);
    tod_edges(20);
    peek(A_TEN, rd); check_eq("halt_tenths", rd, 8'h00);
    peek(A_HR, rd);  check_eq("halt_hr", rd, 8'h03);
    write_reg(A_TEN, 8'h00, 1'b0);
    tod_edges(5);
    peek(A_TEN, rd); check_eq("resume_5edges", rd, 8'h00);
    tod_edges(1);
    peek(A_TEN, rd); check_eq("resume_6edges", rd, 8'h01);

    // hours 09 -> 10, and invalid BCD steps without carry
    preset(8'h09, 8'h59, 8'h59, 8'h09);
    tod_edges(6);
    peek(A_HR, rd);  check_eq("hr09_to_10", rd, 8'h10);
    write_reg(A_TEN, 8'h0C, 1'b0);
    tod_edges(6);
    peek(A_TEN, rd); check_eq("bad_bcd_tenths", rd, 8'h0D);
    peek(A_SEC, rd); check_eq("bad_bcd_nocarry", rd, 8'h00);

    // 4: read latch
    preset(8'h01, 8'h02, 8'h03, 8'h04);
    read_reg(A_HR, rd); check_eq("latch_hr", rd, 8'h01);
    tod_edges(18);
    peek(A_TEN, rd);     check_eq("latched_peek_tenths", rd, 8'h04);
    read_reg(A_MIN, rd); check_eq("latched_min", rd, 8'h02);
    read_reg(A_SEC, rd); check_eq("latched_sec", rd, 8'h03);
    read_reg(A_TEN, rd); check_eq("latched_tenths", rd, 8'h04);
    peek(A_TEN, rd);     check_eq("unlatched_tenths", rd, 8'h07);
    read_reg(A_HR, rd);  check_eq("unlatched_hr", rd, 8'h01);
    read_reg(A_TEN, rd);

    // 5: alarm pulse
    write_reg(A_HR, 8'h01, 1'b1);
    write_reg(A_MIN, 8'h00, 1'b1);
    write_reg(A_SEC, 8'h00, 1'b1);
    write_reg(A_TEN, 8'h05, 1'b1);
    sel_50hz = 1'b1;
    preset(8'h01, 8'h00, 8'h00, 8'h00);
    cycles(2);
    irq_base = irq_cnt;
    tod_edges(24);
    check_eq("alarm_none_before", irq_cnt - irq_base, 0);
    tod_edges(1);
    peek(A_TEN, rd); check_eq("alarm_tenths5", rd, 8'h05);
    check_eq("alarm_irq_cycle", alarm_irq, 1'b1);
    tod_edges(10);
    check_eq("alarm_single_pulse", irq_cnt - irq_base, 1);
    peek(A_TEN, rd); check_eq("alarm_then_tenths", rd, 8'h07);
    write_reg(A_TEN, 8'h07, 1'b1);
    cycles(3);
    check_eq("alarm_on_alarm_write", irq_cnt - irq_base, 2);
    write_reg(A_TEN, 8'h07, 1'b1);
    cycles(3);
    check_eq("alarm_static_no_repulse", irq_cnt - irq_base, 2);

    // 6: hours write of 12 with pm=0
    write_reg(A_HR, 8'h12, 1'b0);
    peek(A_HR, rd); check_eq("hr12_pm_flip", rd, HR12_AM_RD);

    // reset mid-operation drops latch and halt state
    read_reg(A_HR, rd);
    tod_in = 1'b1;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    tod_in = 1'b0;
    cycles(1);
    peek(A_HR, rd);  check_eq("midrst_hr", rd, 8'h01);
    peek(A_TEN, rd); check_eq("midrst_tenths", rd, 8'h00);
    check_eq("midrst_irq", alarm_irq, 1'b0);
    tod_edges(12);
    peek(A_TEN, rd); check_eq("midrst_halted", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
